// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine and its multipliers.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_STEP,
    ST_MUL,
    ST_DONE
  } state_t;

  localparam int unsigned ONE = 1;

  function automatic int opw(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/rsa_modexp_if.sv
// Start/busy/done job interface between a caller and rsa_modexp.
interface rsa_modexp_if
  import rsa_pkg::*;
#(
  parameter int W = 32
);
  localparam int OPW = opw(W);

  logic           start;
  logic [OPW-1:0] n;
  logic [OPW-1:0] exp;
  logic [OPW-1:0] msg;
  logic [OPW-1:0] result;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    output start, n, exp, msg,
    input  result, busy, done, err
  );

  modport slave (
    input  start, n, exp, msg,
    output result, busy, done, err
  );
endinterface

// File: rtl/rsa_modexp_mod_mult.sv
// Bit-serial interleaved modular multiplier: o_p = i_a*i_b mod i_n, MSB-first over 2W bits.
module mod_mult
  import rsa_pkg::*;
#(
  parameter  int W   = 32,
  localparam int OPW = opw(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  input  logic [OPW-1:0] i_n,
  output logic [OPW-1:0] o_p,
  output logic           o_done
);
  localparam int CW = $clog2(OPW + 1);

  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic [OPW-1:0] r_n;
  logic [OPW-1:0] r_acc;
  logic [OPW-1:0] r_p;
  logic [CW-1:0]  r_cnt;
  logic           r_run;
  logic           r_done;

  logic [OPW+1:0] w_n_ext;
  logic [OPW+1:0] w_sum;
  logic [OPW+1:0] w_sub1;
  logic [OPW+1:0] w_sub2;
  logic [OPW-1:0] w_next;

  // Operands are below n, so 2r+a < 3n: two conditional subtractions always suffice.
  assign w_n_ext = {2'b00, r_n};
  assign w_sum   = {1'b0, r_acc, 1'b0} + (r_b[OPW-1] ? {2'b00, r_a} : '0);
  assign w_sub1  = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
  assign w_sub2  = (w_sub1 >= w_n_ext) ? (w_sub1 - w_n_ext) : w_sub1;
  assign w_next  = w_sub2[OPW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_acc  <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_n   <= i_n;
        r_acc <= '0;
        r_cnt <= CW'(OPW - 1);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_acc <= w_next;
        r_b   <= {r_b[OPW-2:0], 1'b0};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == '0) begin
          r_run  <= 1'b0;
          r_p    <= w_next;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_p    = r_p;
  assign o_done = r_done;
endmodule

// File: rtl/rsa_modexp.sv
// RSA modular exponentiation msg^exp mod n, right-to-left square-and-multiply
// over two mod_mult instances running in parallel.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// CHECK | reject n < 2 or msg >= n
// STEP  | finish if exponent exhausted, else launch both multipliers
// MUL   | wait for multipliers, fold results, shift exponent
// DONE  | one-cycle done pulse with registered result/err
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter  int W   = 32,
  localparam int OPW = opw(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  rsa_modexp_if.slave  bus
);
  state_t         r_state;
  state_t         w_next_state;

  logic [OPW-1:0] r_n;
  logic [OPW-1:0] r_exp;
  logic [OPW-1:0] r_base;
  logic [OPW-1:0] r_acc;
  logic [OPW-1:0] r_result;
  logic           r_err;

  logic           w_mul_start;
  logic           w_illegal;
  logic           w_mul_done;
  logic [OPW-1:0] w_m0_p;
  logic [OPW-1:0] w_m1_p;
  logic           w_m0_done;
  logic           w_m1_done;

  assign w_illegal  = (r_n < OPW'(2)) || (r_base >= r_n);
  assign w_mul_done = w_m0_done & w_m1_done;

  mod_mult #(.W(W)) u_mul_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (r_acc),
    .i_b     (r_base),
    .i_n     (r_n),
    .o_p     (w_m0_p),
    .o_done  (w_m0_done)
  );

  mod_mult #(.W(W)) u_mul_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (r_base),
    .i_b     (r_base),
    .i_n     (r_n),
    .o_p     (w_m1_p),
    .o_done  (w_m1_done)
  );

  always_comb begin
    w_next_state = r_state;
    w_mul_start  = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next_state = ST_CHECK;
      ST_CHECK: w_next_state = w_illegal ? ST_DONE : ST_STEP;
      ST_STEP: begin
        if (r_exp == '0) begin
          w_next_state = ST_DONE;
        end else begin
          w_mul_start  = 1'b1;
          w_next_state = ST_MUL;
        end
      end
      ST_MUL:   if (w_mul_done) w_next_state = ST_STEP;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_n      <= '0;
      r_exp    <= '0;
      r_base   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_n    <= bus.n;
            r_exp  <= bus.exp;
            r_base <= bus.msg;
            r_acc  <= OPW'(ONE);
          end
        end
        ST_CHECK: begin
          if (w_illegal) begin
            r_acc    <= '0;
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        ST_STEP: begin
          if (r_exp == '0) begin
            r_result <= r_acc;
            r_err    <= 1'b0;
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            if (r_exp[0]) r_acc <= w_m0_p;
            r_base <= w_m1_p;
            r_exp  <= r_exp >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;
  assign bus.err    = r_err;
endmodule

// File: tb/tb_rsa_modexp.sv
// Scoreboard bench for rsa_modexp (W=8): directed RSA vectors plus random jobs.
`timescale 1ns/1ps
module tb_rsa_modexp;
  localparam int W    = 8;
  localparam int OPW  = 2 * W;
  localparam int BITC = 2 * W + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  rsa_modexp_if #(.W(W)) bus ();

  rsa_modexp #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint res;
    bit     err;
    longint lat;
    longint t0;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic longint cyc_id();
    return longint'($time) / 10;
  endfunction

  function automatic longint modpow(input longint m, input longint e, input longint nn);
    longint r;
    r = 1 % nn;
    for (int i = OPW - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * m) % nn;
    end
    return r;
  endfunction

  function automatic int bit_len(input longint e);
    int b;
    b = 0;
    while ((e >> b) != 0) b++;
    return b;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        check("result", longint'(bus.result), e.res);
        check("err", longint'(bus.err), longint'(e.err));
        check("latency", cyc_id() - e.t0, e.lat);
        check("busy_at_done", longint'(bus.busy), 1);
      end
    end
  end

  task automatic issue(input longint nn, input longint ee, input longint mm,
                       input bit push, input bit have_res, input longint res);
    exp_t e;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.n     = OPW'(nn);
    bus.exp   = OPW'(ee);
    bus.msg   = OPW'(mm);
    e.err = (nn < 2) || (mm >= nn);
    if (have_res)   e.res = res;
    else if (e.err) e.res = 0;
    else            e.res = modpow(mm, ee, nn);
    e.lat = e.err ? 2 : 3 + bit_len(ee) * BITC;
    e.t0  = cyc_id() + 1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.n     = OPW'($urandom);
    bus.exp   = OPW'($urandom);
    bus.msg   = OPW'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint nn, mm, ee;
    bus.start = 1'b0;
    bus.n     = '0;
    bus.exp   = '0;
    bus.msg   = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_result", longint'(bus.result), 0);
    check("rst_err", longint'(bus.err), 0);
    #20 rst_n = 1'b1;

    // encrypt, then confirm the result is held after the pulse
    issue(3233, 17, 65, 1, 1, 2790);
    drain();
    repeat (3) @(negedge clk);
    check("result_held", longint'(bus.result), 2790);
    check("done_low_after", longint'(bus.done), 0);
    check("busy_low_after", longint'(bus.busy), 0);

    issue(3233, 2753, 2790, 1, 1, 65);
    drain();
    issue(3233, 0, 1234, 1, 1, 1);
    drain();
    issue(3233, 5, 0, 1, 1, 0);
    drain();
    issue(3233, 17, 3233, 1, 1, 0);
    drain();
    issue(1, 3, 0, 1, 1, 0);
    drain();

    // start while busy at cycle 10 must be ignored
    issue(3233, 17, 65, 1, 1, 2790);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.n     = 16'd3233;
    bus.exp   = 16'd3;
    bus.msg   = 16'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();

    // asynchronous reset at cycle 40 aborts the job without a done pulse
    issue(3233, 17, 65, 0, 1, 2790);
    repeat (39) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_done", longint'(bus.done), 0);
    check("abort_result", longint'(bus.result), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    issue(3233, 17, 65, 1, 1, 2790);
    drain();

    for (int k = 0; k < 16; k++) begin
      nn = longint'($urandom_range(65535, 2));
      mm = longint'($urandom_range(int'(nn) - 1, 0));
      ee = longint'($urandom_range(65535, 0));
      if (k % 5 == 4) begin
        if (k % 10 == 4) nn = longint'($urandom_range(1, 0));
        else             mm = longint'($urandom_range(65535, int'(nn)));
      end
      issue(nn, ee, mm, 1, 0, 0);
      drain();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
